// File: rtl/bf_arb_pkg.sv
// Shared types and helpers for the bloom-filter stream arbiter.
// Optional feature macro used by the arbiter: BF_STREAM_ARB_PRIO0_EN.
package bf_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Behavioural round-robin pick over a request vector padded to RR_MAX_REQ bits.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int                    n_req);
    rr_pick_t res;
    int       pos;
    res = '0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= n_req) pos = pos - n_req;
      if ((i < n_req) && !res.found && req[pos[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bf_stream_arbiter_picker.sv
// Round-robin picker: rotates the request vector so ptr sits at bit 0,
// finds the lowest set bit, then maps that offset back to an absolute index.
module bf_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_REQ);

  logic [N_REQ-1:0] req_rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    pos;
  logic [ID_W:0]    room;

  // Rotate, priority-encode from the pointer, and unrotate back to a requester index.
  always_comb begin
    req_rot = '0;
    pos     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= N_VAL) pos = pos - N_VAL;
      req_rot[i] = req[pos[ID_W-1:0]];
    end
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
    room = N_VAL - {1'b0, ptr};
    if ({1'b0, off} >= room) idx = off - room[ID_W-1:0];
    else                     idx = ptr + off;
  end

endmodule

// File: rtl/bf_stream_arbiter.sv
// N_REQ-to-1 stream arbiter with round-robin grant, packet lock and one output
// register stage carrying the source index with each beat.
// Optional macro BF_STREAM_ARB_PRIO0_EN: requester 0 wins idle arbitration and
// its grants leave the round-robin pointer untouched.
module bf_stream_arbiter
  import bf_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 32,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [N_REQ-1:0]        valid_i,
  input  logic [N_REQ-1:0]        last_i,
  output logic [N_REQ-1:0]        ready_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    last_o,
  output logic [ID_W-1:0]         id_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  arb_state_t        state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              stage_en;
  logic              accept;
  logic              keep_ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              sel_valid;

  bf_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (valid_i),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign stage_en = ready_i || !valid_o;
  assign accept   = stage_en && gnt_any && sel_valid;
  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef BF_STREAM_ARB_PRIO0_EN
  assign keep_ptr = (gnt_idx == '0);
`else
  assign keep_ptr = 1'b0;
`endif

  // Choose the granted requester: the lock owner mid-packet, otherwise the idle arbitration winner.
  always_comb begin
    gnt_idx = pick_idx;
    gnt_any = pick_found;
    if (state == ARB_LOCK) begin
      gnt_idx = owner;
      gnt_any = 1'b1;
    end
`ifdef BF_STREAM_ARB_PRIO0_EN
    else if (valid_i[0]) begin
      gnt_idx = '0;
      gnt_any = 1'b1;
    end
`endif
  end

  // Mux the granted lane and drive a one-hot ready that is silenced during reset.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    ready_o   = '0;
    for (int g = 0; g < N_REQ; g++) begin
      if (gnt_idx == ID_W'(g)) begin
        sel_data  = data_i[g*DATA_W +: DATA_W];
        sel_last  = last_i[g];
        sel_valid = valid_i[g];
        ready_o[g] = arstn_i && stage_en && gnt_any;
      end
    end
  end

  // Packet lock FSM and round-robin pointer, advanced only on accepted last beats.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (accept) begin
      if (state == ARB_IDLE && !sel_last) begin
        state <= ARB_LOCK;
        owner <= gnt_idx;
      end else if (sel_last) begin
        state <= ARB_IDLE;
        if (!keep_ptr) ptr <= ptr_next;
      end
    end
  end

  // Output register stage: loads on stage enable, holds under backpressure.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      id_o    <= '0;
    end else if (stage_en) begin
      valid_o <= accept;
      if (accept) begin
        data_o <= sel_data;
        last_o <= sel_last;
        id_o   <= gnt_idx;
      end
    end
  end

endmodule
